// File: rtl/ngram_encoder_pkg.sv
// Shared constants and types for the N-gram hypervector encoder.
package ngram_encoder_pkg;

  localparam int unsigned HV_DIMENSION_DEFAULT = 2000;
  localparam int unsigned NGRAM_MAX_DEFAULT    = 5;

  typedef enum logic {
    ST_IDLE,
    ST_OUTPUT
  } state_e;

  // Requested N is clamped into 1..nmax; 0 selects unigram mode.
  function automatic int unsigned clamp_ngram(input int unsigned req, input int unsigned nmax);
    if (req == 0) return 1;
    if (req > nmax) return nmax;
    return req;
  endfunction

endpackage

// File: rtl/ngram_encoder_hv_permute.sv
// Hypervector permutation: rotate by one position toward higher indices.
module hv_permute #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [0:WIDTH-1] i_x,
  output logic [0:WIDTH-1] o_y
);

  assign o_y = {i_x[WIDTH-1], i_x[0:WIDTH-2]};

endmodule

// File: rtl/ngram_encoder.sv
// Streaming N-gram encoder: XOR of the current hypervector with progressively permuted history.
module ngram_encoder
  import ngram_encoder_pkg::*;
#(
  parameter int unsigned HV_DIMENSION = HV_DIMENSION_DEFAULT,
  parameter int unsigned NGRAM_MAX    = NGRAM_MAX_DEFAULT,
  parameter int unsigned NW           = $clog2(NGRAM_MAX + 1)
) (
  input  logic                    Clk_CI,
  input  logic                    Reset_RI,
  input  logic                    ValidIn_SI,
  output logic                    ReadyOut_SO,
  input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
  input  logic [NW-1:0]           NGramSize_SI,
  input  logic                    Clear_SI,
  output logic                    ValidOut_SO,
  input  logic                    ReadyIn_SI,
  output logic [0:HV_DIMENSION-1] HypervectorOut_DO
);

  // History stage H[k] is stored at r_hist[k-1]; one dummy stage keeps NGRAM_MAX=1 legal.
  localparam int unsigned HS = (NGRAM_MAX > 1) ? NGRAM_MAX - 1 : 1;

  state_e                    r_state, w_state_next;
  logic [NW-1:0]             r_n, r_fill;
  logic [0:HV_DIMENSION-1]   r_hist [HS];
  logic [0:HV_DIMENSION-1]   w_perm [HS];
  logic [0:HV_DIMENSION-1]   w_result;
  logic [0:HV_DIMENSION-1]   r_out;
  logic                      w_accept, w_due;

  for (genvar k = 0; k < HS; k++) begin : g_perm
    if (k == 0) begin : g_first
      hv_permute #(.WIDTH(HV_DIMENSION)) u_perm (.i_x(HypervectorIn_DI), .o_y(w_perm[k]));
    end else begin : g_rest
      hv_permute #(.WIDTH(HV_DIMENSION)) u_perm (.i_x(r_hist[k-1]), .o_y(w_perm[k]));
    end
  end

  assign ReadyOut_SO = !Reset_RI && !Clear_SI && ((r_state == ST_IDLE) || ReadyIn_SI);
  assign w_accept    = ValidIn_SI && ReadyOut_SO;
  assign w_due       = (r_fill == r_n - NW'(1));
  assign ValidOut_SO = (r_state == ST_OUTPUT);
  assign HypervectorOut_DO = r_out;

  always_comb begin
    w_result = HypervectorIn_DI;
    for (int unsigned k = 0; k < HS; k++) begin
      if (NGRAM_MAX > 1 && (k + 1) < 32'(r_n)) w_result = w_result ^ r_hist[k];
    end
  end

  always_comb begin
    w_state_next = ST_IDLE;
    if (Clear_SI)                                   w_state_next = ST_IDLE;
    else if (w_accept && w_due)                     w_state_next = ST_OUTPUT;
    else if (r_state == ST_OUTPUT && !ReadyIn_SI)   w_state_next = ST_OUTPUT;
  end

  always_ff @(posedge Clk_CI or posedge Reset_RI) begin
    if (Reset_RI) begin
      r_state <= ST_IDLE;
      r_n     <= NW'(NGRAM_MAX);
      r_fill  <= '0;
      r_out   <= '0;
      for (int unsigned k = 0; k < HS; k++) r_hist[k] <= '0;
    end else begin
      r_state <= w_state_next;
      if (Clear_SI) begin
        r_n    <= NW'(clamp_ngram(32'(NGramSize_SI), NGRAM_MAX));
        r_fill <= '0;
        r_out  <= '0;
        for (int unsigned k = 0; k < HS; k++) r_hist[k] <= '0;
      end else if (w_accept) begin
        for (int unsigned k = 0; k < HS; k++) r_hist[k] <= w_perm[k];
        if (w_due) r_out  <= w_result;
        else       r_fill <= r_fill + NW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ngram_encoder.sv
// Directed checks of ngram_encoder with HV_DIMENSION=8, NGRAM_MAX=4.
module tb_ngram_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       vin, rin, clr;
  logic [2:0] nsz;
  logic [7:0] din;
  logic       rdy, vout;
  logic [7:0] dout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ngram_encoder #(.HV_DIMENSION(8), .NGRAM_MAX(4)) dut (
    .Clk_CI(clk), .Reset_RI(rst), .ValidIn_SI(vin), .ReadyOut_SO(rdy),
    .HypervectorIn_DI(din), .NGramSize_SI(nsz), .Clear_SI(clr),
    .ValidOut_SO(vout), .ReadyIn_SI(rin), .HypervectorOut_DO(dout)
  );

  typedef struct {
    logic       valid, rin, clr;
    logic [2:0] nsz;
    logic [7:0] din;
    logic       evout, erdy;
    logic [7:0] edout;
  } vec_t;

  vec_t tbl [20];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic r, input logic c, input logic [2:0] n, input logic [7:0] d);
    vin = v; rin = r; clr = c; nsz = n; din = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic v, input logic c, input logic [2:0] n, input logic [7:0] d,
                              input logic ev, input logic er, input logic [7:0] ed);
    vec_t t;
    t.valid = v; t.rin = 1'b1; t.clr = c; t.nsz = n; t.din = d;
    t.evout = ev; t.erdy = er; t.edout = ed;
    return t;
  endfunction

  initial begin
    // Outputs listed per row are those visible during that row, before its clock edge.
    tbl[0]  = mk(0, 1, 3, 8'h00, 0, 0, 8'h00);
    tbl[1]  = mk(1, 0, 0, 8'h01, 0, 1, 8'h00);
    tbl[2]  = mk(1, 0, 0, 8'h02, 0, 1, 8'h00);
    tbl[3]  = mk(1, 0, 0, 8'h04, 0, 1, 8'h00);
    tbl[4]  = mk(0, 0, 0, 8'h00, 1, 1, 8'h45);
    tbl[5]  = mk(0, 0, 0, 8'h00, 0, 1, 8'h45);
    tbl[6]  = mk(0, 1, 1, 8'h00, 0, 0, 8'h45);
    tbl[7]  = mk(1, 0, 0, 8'h3C, 0, 1, 8'h00);
    tbl[8]  = mk(1, 0, 0, 8'hA5, 1, 1, 8'h3C);
    tbl[9]  = mk(0, 0, 0, 8'h00, 1, 1, 8'hA5);
    tbl[10] = mk(0, 0, 0, 8'h00, 0, 1, 8'hA5);
    tbl[11] = mk(0, 1, 0, 8'h00, 0, 0, 8'hA5);
    tbl[12] = mk(1, 0, 0, 8'h11, 0, 1, 8'h00);
    tbl[13] = mk(0, 0, 0, 8'h00, 1, 1, 8'h11);
    tbl[14] = mk(0, 1, 7, 8'h00, 0, 0, 8'h11);
    tbl[15] = mk(1, 0, 0, 8'h01, 0, 1, 8'h00);
    tbl[16] = mk(1, 0, 0, 8'h02, 0, 1, 8'h00);
    tbl[17] = mk(1, 0, 0, 8'h04, 0, 1, 8'h00);
    tbl[18] = mk(1, 0, 0, 8'h08, 0, 1, 8'h00);
    tbl[19] = mk(0, 0, 0, 8'h00, 1, 1, 8'hAA);

    rst = 1'b1;
    set_in(0, 1, 0, 0, 8'h00);
    #2;
    check("reset_rdy",  8'(rdy),  8'h00);
    check("reset_vout", 8'(vout), 8'h00);
    check("reset_dout", dout,     8'h00);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      set_in(tbl[i].valid, tbl[i].rin, tbl[i].clr, tbl[i].nsz, tbl[i].din);
      @(negedge clk);
      check($sformatf("row%0d_vout", i), 8'(vout), 8'(tbl[i].evout));
      check($sformatf("row%0d_rdy", i),  8'(rdy),  8'(tbl[i].erdy));
      check($sformatf("row%0d_dout", i), dout,     tbl[i].edout);
      next_cycle();
    end

    // Backpressure hold with N=2
    set_in(0, 0, 1, 2, 8'h00); next_cycle();
    set_in(1, 0, 0, 0, 8'h10); next_cycle();
    set_in(1, 0, 0, 0, 8'h20); next_cycle();
    set_in(1, 0, 0, 0, 8'h40);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("hold%0d_vout", i), 8'(vout), 8'h01);
      check($sformatf("hold%0d_dout", i), dout,     8'h28);
      check($sformatf("hold%0d_rdy", i),  8'(rdy),  8'h00);
      next_cycle();
    end
    set_in(1, 1, 0, 0, 8'h40);
    @(negedge clk);
    check("release_rdy", 8'(rdy), 8'h01);
    next_cycle();
    set_in(0, 0, 0, 0, 8'h00);
    @(negedge clk);
    check("release_vout", 8'(vout), 8'h01);
    check("release_dout", dout,     8'h50);
    next_cycle();

    // Clear while an output is pending
    set_in(1, 0, 1, 2, 8'h77);
    @(negedge clk);
    check("clr_rdy", 8'(rdy), 8'h00);
    next_cycle();
    set_in(1, 0, 0, 0, 8'h01);
    @(negedge clk);
    check("clr_vout", 8'(vout), 8'h00);
    check("clr_dout", dout,     8'h00);
    check("clr_rdy2", 8'(rdy),  8'h01);
    next_cycle();
    set_in(1, 0, 0, 0, 8'h02);
    @(negedge clk);
    check("clr_warm_vout", 8'(vout), 8'h00);
    next_cycle();
    set_in(0, 0, 0, 0, 8'h00);
    @(negedge clk);
    check("clr_out_vout", 8'(vout), 8'h01);
    check("clr_out_dout", dout,     8'h82);

    // Asynchronous reset mid-OUTPUT
    #1 rst = 1'b1;
    #1;
    check("arst_vout", 8'(vout), 8'h00);
    check("arst_dout", dout,     8'h00);
    check("arst_rdy",  8'(rdy),  8'h00);
    #1 rst = 1'b0;
    next_cycle();
    check("post_rst_rdy", 8'(rdy), 8'h01);
    set_in(1, 1, 0, 0, 8'h01); next_cycle();
    set_in(1, 1, 0, 0, 8'h02); next_cycle();
    set_in(1, 1, 0, 0, 8'h04); next_cycle();
    set_in(1, 1, 0, 0, 8'h08);
    @(negedge clk);
    check("rstn_third_vout", 8'(vout), 8'h00);
    next_cycle();
    set_in(0, 1, 0, 0, 8'h00);
    @(negedge clk);
    check("rstn_fourth_vout", 8'(vout), 8'h01);
    check("rstn_fourth_dout", dout,     8'hAA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
